// File: rtl/ins_pkg.sv
// Shared RV32I encoder definitions: format selector codes, common opcodes and a legality helper.
package ins_pkg;

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_S  = 3'd2;
  localparam logic [2:0] FMT_SB = 3'd3;
  localparam logic [2:0] FMT_U  = 3'd4;
  localparam logic [2:0] FMT_UJ = 3'd5;

  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  function automatic logic fmt_legal(input logic [2:0] f);
    return (f <= FMT_UJ);
  endfunction

endpackage

// File: rtl/ins_fifo.sv
// Synchronous DEPTH-entry FIFO with occupancy count; head visible one cycle after a push into an empty FIFO.
// Pushes while full and pops while empty are ignored; head data reads as zero when empty.
module ins_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     head_vld,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign head_vld = (count != '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && head_vld;

  // Storage is not reset; the head is masked while empty instead.
  assign head_dat = head_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer width equals log2(DEPTH), so increments wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ins_encoder.sv
// RV32I field packer feeding an address-tagged output FIFO; one cycle to head, in_ready low only when full.
// Optional immediate range checking is enabled with INS_ENCODER_RANGE_CHECK_EN.
module ins_encoder
  import ins_pkg::*;
#(
  parameter int                DEPTH     = 2,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             fmt,
  input  logic [6:0]             opcode,
  input  logic [4:0]             rd,
  input  logic [2:0]             funct3,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  input  logic [6:0]             funct7,
  input  logic [31:0]            imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            instruction,
  output logic [ADDR_W-1:0]      addr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_illegal,
  output logic                   err_range
);

  logic              accept;
  logic              legal;
  logic              push;
  logic              pop;
  logic              full;
  logic [31:0]       word;
  logic [ADDR_W-1:0] next_addr;
  logic [31+ADDR_W:0] head_dat;

  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign legal    = fmt_legal(fmt);
  assign push     = accept && legal;
  assign pop      = out_valid && out_ready;

  always_comb begin
    word = '0;
    case (fmt)
      FMT_R:   word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_SB:  word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   word = {imm[31:12], rd, opcode};
      FMT_UJ:  word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: word = '0;
    endcase
  end

  // Only legal words consume an address; illegal bundles are swallowed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_addr   <= BASE_ADDR;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= accept && !legal;
      if (push) next_addr <= next_addr + ADDR_W'(4);
    end
  end

`ifdef INS_ENCODER_RANGE_CHECK_EN
  logic signed [31:0] simm;
  logic               range_bad;

  assign simm = $signed(imm);

  always_comb begin
    range_bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
      FMT_SB:       range_bad = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
      FMT_UJ:       range_bad = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
      FMT_U:        range_bad = (imm[11:0] != 12'd0);
      default:      range_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_range <= 1'b0;
    end else begin
      err_range <= push && range_bad;
    end
  end
`else
  assign err_range = 1'b0;
`endif

  ins_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32 + ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .push     (push),
    .push_dat ({word, next_addr}),
    .pop      (pop),
    .head_dat (head_dat),
    .head_vld (out_valid),
    .count    (count),
    .full     (full)
  );

  assign instruction = head_dat[31+ADDR_W:ADDR_W];
  assign addr        = head_dat[ADDR_W-1:0];

endmodule

// File: tb/tb_ins_encoder.sv
// Directed self-checking bench for ins_encoder with hand-computed RV32I encodings.
module tb_ins_encoder;
  import ins_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic [31:0] addr;
  logic [1:0]  count;
  logic        err_illegal;
  logic        err_range;

  int checks = 0;
  int errors = 0;

  ins_encoder #(.DEPTH(2), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .instruction(instruction), .addr(addr), .count(count),
    .err_illegal(err_illegal), .err_range(err_range)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                            input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                            input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; funct3 = f3; rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
  endtask

  // Present one bundle, wait (bounded) for in_ready, complete the handshake; returns at edge+1.
  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                       input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [6:0] f7, input logic [31:0] im);
    int waited;
    set_fields(f, op, d, f3, s1, s2, f7, im);
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL drive_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    set_fields(3'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instruction: got %h want 0", instruction); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr); end
    checks++; if (err_illegal !== 1'b0 || err_range !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b%0b want 00", err_illegal, err_range); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_r_format();
    apply_reset();
    out_ready = 1'b1;
    drive(FMT_R, OP_REG, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFF);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0b want 1", out_valid); end
    checks++; if (instruction !== 32'h002081B3) begin errors++; $display("FAIL add_word: got %h want 002081b3", instruction); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL add_addr: got %h want 0", addr); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL add_popped: valid %0b count %0d want 0 0", out_valid, count); end
  endtask

  task automatic test_i_s_format();
    apply_reset();
    drive(FMT_I, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF);
    drive(FMT_S, OP_STORE, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
    checks++; if (count !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL is_full: count %0d in_ready %0b want 2 0", count, in_ready); end
    checks++; if (instruction !== 32'hFFF00093 || addr !== 32'h0) begin errors++; $display("FAIL addi_word: got %h@%h want fff00093@0", instruction, addr); end
    pop_one();
    checks++; if (instruction !== 32'h0020A423 || addr !== 32'h4) begin errors++; $display("FAIL sw_word: got %h@%h want 0020a423@4", instruction, addr); end
    pop_one();
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL is_drain: count %0d want 0", count); end
  endtask

  task automatic test_sb_u_uj();
    apply_reset();
    drive(FMT_SB, OP_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC);
    checks++; if (instruction !== 32'hFE208EE3 || addr !== 32'h0) begin errors++; $display("FAIL beq_word: got %h@%h want fe208ee3@0", instruction, addr); end
    pop_one();
    drive(FMT_UJ, OP_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_0800);
    checks++; if (instruction !== 32'h001000EF || addr !== 32'h4) begin errors++; $display("FAIL jal_word: got %h@%h want 001000ef@4", instruction, addr); end
    pop_one();
    drive(FMT_U, OP_LUI, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000);
    checks++; if (instruction !== 32'h123452B7 || addr !== 32'h8) begin errors++; $display("FAIL lui_word: got %h@%h want 123452b7@8", instruction, addr); end
    checks++; if (err_range !== 1'b0) begin errors++; $display("FAIL lui_range: got %0b want 0", err_range); end
    pop_one();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    in_valid = 1'b1;
    set_fields(FMT_R, OP_REG, 5'd1, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    @(posedge clk); #1;
    set_fields(FMT_R, OP_REG, 5'd2, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    @(posedge clk); #1;
    set_fields(FMT_R, OP_REG, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    checks++; if (in_ready !== 1'b0 || count !== 2'd2) begin errors++; $display("FAIL b2b_full: in_ready %0b count %0d want 0 2", in_ready, count); end
    @(posedge clk); #1;
    checks++; if (count !== 2'd2 || instruction !== 32'h002080B3) begin errors++; $display("FAIL b2b_hold: count %0d word %h want 2 002080b3", count, instruction); end
    out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_no_bypass: in_ready %0b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (count !== 2'd1 || instruction !== 32'h00208133 || addr !== 32'h4) begin errors++; $display("FAIL b2b_second: count %0d %h@%h want 1 00208133@4", count, instruction, addr); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (count !== 2'd1 || instruction !== 32'h002081B3 || addr !== 32'h8) begin errors++; $display("FAIL b2b_third: count %0d %h@%h want 1 002081b3@8", count, instruction, addr); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: count %0d valid %0b want 0 0", count, out_valid); end
  endtask

  task automatic test_illegal();
    apply_reset();
    drive(3'd6, OP_REG, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL illegal_pulse: got %0b want 1", err_illegal); end
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL illegal_nopush: count %0d valid %0b want 0 0", count, out_valid); end
    @(posedge clk); #1;
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL illegal_one_cycle: got %0b want 0", err_illegal); end
    drive(3'd7, OP_REG, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    checks++; if (err_illegal !== 1'b1 || count !== 2'd0) begin errors++; $display("FAIL illegal7: pulse %0b count %0d want 1 0", err_illegal, count); end
    drive(FMT_R, OP_REG, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    checks++; if (instruction !== 32'h002081B3 || addr !== 32'h0) begin errors++; $display("FAIL illegal_addr: got %h@%h want 002081b3@0", instruction, addr); end
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL legal_no_pulse: got %0b want 0", err_illegal); end
    pop_one();
  endtask

  task automatic test_range();
    logic exp_flag;
`ifdef INS_ENCODER_RANGE_CHECK_EN
    exp_flag = 1'b1;
`else
    exp_flag = 1'b0;
`endif
    apply_reset();
    drive(FMT_I, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4096);
    checks++; if (err_range !== exp_flag) begin errors++; $display("FAIL range_flag: got %0b want %0b", err_range, exp_flag); end
    checks++; if (count !== 2'd1 || instruction !== 32'h00000093) begin errors++; $display("FAIL range_pushed: count %0d word %h want 1 00000093", count, instruction); end
    pop_one();
    drive(FMT_I, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2047);
    checks++; if (err_range !== 1'b0 || instruction !== 32'h7FF00093) begin errors++; $display("FAIL range_ok: flag %0b word %h want 0 7ff00093", err_range, instruction); end
    pop_one();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive(FMT_R, OP_REG, 5'd1, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    drive(FMT_R, OP_REG, 5'd2, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL mid_fill: count %0d want 2", count); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_async: count %0d valid %0b want 0 0", count, out_valid); end
    @(posedge clk); #1;
    reset = 1'b0;
    drive(FMT_R, OP_REG, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    checks++; if (addr !== 32'h0 || instruction !== 32'h002081B3 || count !== 2'd1) begin errors++; $display("FAIL mid_base: %h@%h count %0d want 002081b3@0 1", instruction, addr, count); end
    pop_one();
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_fields(3'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    #12;
    test_reset();
    test_r_format();
    test_i_s_format();
    test_sb_u_uj();
    test_back_to_back();
    test_illegal();
    test_range();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
